// File: rtl/dot_scan_ctrl_if.sv
// dot_scan_ctrl_if: frame handshake and dot-matrix drive signals of the column-scan driver
interface dot_scan_ctrl_if;
   logic [69:0] frame_in;
   logic        frame_valid;
   logic        frame_ready;
   logic [6:0]  dot_d;
   logic [9:0]  dot_scan;
   logic        frame_start;
   modport master (output frame_in, frame_valid, input frame_ready, dot_d, dot_scan, frame_start);
   modport slave  (input frame_in, frame_valid, output frame_ready, dot_d, dot_scan, frame_start);
endinterface

// File: rtl/dot_scan_ctrl.sv
// dot_scan_ctrl: double-buffered 10x7 dot-matrix column scanner with per-slot blanking
module dot_scan_ctrl #(
   parameter int SCAN_DIV     = 100,
   parameter int BLANK_CYCLES = 4
) (
   input logic            clk,
   input logic            nreset,
   dot_scan_ctrl_if.slave bus
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(SCAN_DIV - 1);
   logic          run_q, run_d;
   logic [3:0]    col_q, col_d;
   logic [PW-1:0] ph_q, ph_d;
   logic [69:0]   act_q, act_d, shd_q, shd_d;
   logic          pend_q, pend_d;
   logic [6:0]    row_q, row_d;
   logic [9:0]    scan_q, scan_d;
   logic          fs_q, fs_d, rdy_q, rdy_d;
   logic          accept, swap, slot_end, blank;
   // Next-state: run_q holds the scan at (0,0) for the first edge after reset so
   // that cycle is the first slot of column 0; outputs derive from next state.
   always_comb begin
      run_d    = 1'b1;
      slot_end = run_q && (ph_q == PH_LAST);
      accept   = bus.frame_valid & ~pend_q;
      swap     = slot_end && (col_q == 4'd9) && pend_q;
      ph_d     = (!run_q || slot_end) ? '0 : ph_q + 1'b1;
      col_d    = !slot_end ? col_q : (col_q == 4'd9) ? 4'd0 : col_q + 4'd1;
      shd_d    = accept ? bus.frame_in : shd_q;
      pend_d   = swap ? 1'b0 : accept ? 1'b1 : pend_q;
      act_d    = swap ? shd_q : act_q;
      blank    = int'(ph_d) < BLANK_CYCLES;
      row_d    = blank ? '0 : 7'(act_d >> (7 * col_d));
      scan_d   = blank ? '0 : 10'd1 << col_d;
      fs_d     = (col_d == 4'd0) && (ph_d == '0);
      rdy_d    = ~pend_d;
   end
   // State and registered outputs, cleared asynchronously.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         run_q  <= 1'b0;
         col_q  <= '0;
         ph_q   <= '0;
         act_q  <= '0;
         shd_q  <= '0;
         pend_q <= 1'b0;
         row_q  <= '0;
         scan_q <= '0;
         fs_q   <= 1'b0;
         rdy_q  <= 1'b1;
      end else begin
         run_q  <= run_d;
         col_q  <= col_d;
         ph_q   <= ph_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         row_q  <= row_d;
         scan_q <= scan_d;
         fs_q   <= fs_d;
         rdy_q  <= rdy_d;
      end
   end
   assign bus.dot_d       = row_q;
   assign bus.dot_scan    = scan_q;
   assign bus.frame_start = fs_q;
   assign bus.frame_ready = rdy_q;
endmodule

// File: tb/tb_dot_scan_ctrl.sv
// tb_dot_scan_ctrl: directed checks of scan timing, double buffering and reset
module tb_dot_scan_ctrl;
   logic clk = 1'b0;
   logic nreset = 1'b0;
   int ncmp = 0;
   int nerr = 0;
   int k = -1;
   logic [69:0] exp_act = '0;
   logic exp_rdy = 1'b1;
   logic [69:0] f1, f2, f3, f4;
   dot_scan_ctrl_if a_if ();
   dot_scan_ctrl_if b_if ();
   dot_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) u_a (.clk(clk), .nreset(nreset), .bus(a_if));
   dot_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(0)) u_b (.clk(clk), .nreset(nreset), .bus(b_if));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [69:0] d);
      a_if.frame_valid = v;
      b_if.frame_valid = v;
      a_if.frame_in = d;
      b_if.frame_in = d;
   endtask
   task automatic run(input int n);
      repeat (n) begin
         int col, ph;
         logic [6:0] v;
         @(negedge clk);
         k++;
         col = (k / 8) % 10;
         ph = k % 8;
         v = 7'(exp_act >> (7 * col));
         chk("a_dot_d", 70'(a_if.dot_d), (ph < 2) ? 70'(0) : 70'(v));
         chk("a_dot_scan", 70'(a_if.dot_scan), (ph < 2) ? 70'(0) : 70'(10'd1 << col));
         chk("a_frame_start", 70'(a_if.frame_start), 70'(k % 80 == 0));
         chk("a_frame_ready", 70'(a_if.frame_ready), 70'(exp_rdy));
         chk("b_dot_d", 70'(b_if.dot_d), 70'(v));
         chk("b_dot_scan", 70'(b_if.dot_scan), 70'(10'd1 << col));
         chk("b_frame_start", 70'(b_if.frame_start), 70'(k % 80 == 0));
         chk("b_frame_ready", 70'(b_if.frame_ready), 70'(exp_rdy));
      end
   endtask
   task automatic chk_reset();
      chk("rst_a_dot_d", 70'(a_if.dot_d), 70'(0));
      chk("rst_a_dot_scan", 70'(a_if.dot_scan), 70'(0));
      chk("rst_a_frame_start", 70'(a_if.frame_start), 70'(0));
      chk("rst_a_frame_ready", 70'(a_if.frame_ready), 70'(1));
      chk("rst_b_dot_scan", 70'(b_if.dot_scan), 70'(0));
      chk("rst_b_frame_ready", 70'(b_if.frame_ready), 70'(1));
   endtask
   initial begin
      for (int c = 0; c < 10; c++) begin
         f1[7*c +: 7] = 7'(c + 1);
         f2[7*c +: 7] = 7'(7'h7f - c);
         f3[7*c +: 7] = 7'(7'h2a ^ c);
         f4[7*c +: 7] = 7'(7'h55 + c);
      end
      drive(1'b0, '0);
      repeat (3) @(negedge clk);
      chk_reset();
      nreset = 1'b1;
      // idle scan, then accept F1 in column 3 of the frame starting at k=240
      run(265);
      drive(1'b1, f1);
      exp_rdy = 1'b0;
      run(1);
      drive(1'b1, f2);
      run(54);
      // F1 swapped in at k=320; held F2 accepted on that first cycle
      exp_act = f1;
      exp_rdy = 1'b1;
      run(1);
      exp_rdy = 1'b0;
      run(1);
      drive(1'b0, '0);
      run(78);
      exp_act = f2;
      exp_rdy = 1'b1;
      run(160);
      // accept F3 on the swap cycle (k=559) with the shadow empty
      drive(1'b1, f3);
      exp_rdy = 1'b0;
      run(1);
      drive(1'b0, '0);
      run(79);
      exp_act = f3;
      exp_rdy = 1'b1;
      run(6);
      // F4 pending, then reset in column 6
      drive(1'b1, f4);
      exp_rdy = 1'b0;
      run(1);
      drive(1'b0, '0);
      run(44);
      nreset = 1'b0;
      #1;
      chk_reset();
      repeat (2) @(negedge clk);
      chk_reset();
      nreset = 1'b1;
      k = -1;
      exp_act = '0;
      exp_rdy = 1'b1;
      run(170);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/dot_scan_ctrl.md
# dot_scan_ctrl

Column-scan driver for the 10×7 LED dot-matrix, downstream of the pattern/scroll generators. It accepts a full 70-bit frame over a valid/ready handshake into a shadow buffer and swaps it into the active buffer only at a frame boundary, so partial frames are never displayed. It then time-multiplexes the active frame onto the shared row bus `dot_d` and the one-hot column strobe `dot_scan`, with a blanking gap at the start of each column slot to suppress ghosting.

## Interface
- `SCAN_DIV`, 100: clk cycles per column slot; must be ≥ 2.
- `BLANK_CYCLES`, 4: blanked cycles at the start of each slot; 0 ≤ `BLANK_CYCLES` < `SCAN_DIV`.
- `clk`  in  1  system clock.
- `nreset`  in  1  asynchronous, active-low reset.
- `frame_in`  in  70  frame data; `frame_in[7c+6:7c]` is column c (c = 0..9); bit r of a column is row r.
- `frame_valid`  in  1  producer has a frame on `frame_in`.
- `frame_ready`  out  1  shadow buffer is empty; a frame is accepted on any edge where `frame_valid & frame_ready`.
- `dot_d`  out  7  row data for the column currently strobed; 0 while blanked.
- `dot_scan`  out  10  one-hot, active-high column strobe; all-zero while blanked.
- `frame_start`  out  1  one-cycle pulse in the first cycle of column 0's slot.

## Operation
- State: column index `col` (0..9), phase counter `ph` (0..`SCAN_DIV`-1), 70-bit active buffer, 70-bit shadow buffer, and `pending` flag (shadow holds an unswapped frame).
- Sub-phase per slot: BLANK while `ph < BLANK_CYCLES`, DRIVE otherwise. In BLANK, `dot_d`=0 and `dot_scan`=0. In DRIVE, `dot_scan`=1<<`col` and `dot_d`=active[`col`].
- `ph` increments every cycle. At `ph`=`SCAN_DIV`-1, `ph` wraps to 0 and `col` advances; `col` wraps from 9 to 0.
- Accept: when `frame_valid & frame_ready`, `shadow<=frame_in` and `pending<=1`. `frame_ready` equals `~pending`.
- Swap: on the last cycle of column 9 (`col`=9, `ph`=`SCAN_DIV`-1), if `pending` is set (registered value), then `active<=shadow` and `pending<=0`. Column 0 of the next frame shows the new data.
- Simultaneous accept and swap-check: if the shadow is empty on the swap cycle and a frame is accepted in that same cycle, it is not swapped this boundary. It waits one full frame.
- `frame_in` is ignored when not accepted. A held `frame_valid` with `frame_ready`=0 has no effect.
- If `BLANK_CYCLES`=0, the slot has no blanking and `dot_scan` moves directly from column to column.

## Timing
- Reset values: `col`=0, `ph`=0, active=0, shadow=0, `pending`=0. Outputs: `dot_d`=0, `dot_scan`=0, `frame_ready`=1, `frame_start`=0.
- All outputs are registered and glitch-free. Outputs in a cycle reflect the (`col`, `ph`) of that same cycle, so the next-state value is registered.
- First edge after reset release is `col`=0, `ph`=0; `frame_start`=1 in that cycle and in every cycle where `col`=0 and `ph`=0. Frame period is 10·`SCAN_DIV` cycles.
- `frame_ready` falls the cycle after an accept. It rises the cycle after the swap, which is the first cycle of column 0.
- Accept-to-display latency: from the accept up to the next frame boundary, at most 10·`SCAN_DIV` cycles plus 1.
- Reset asserted mid-frame: everything returns to reset values immediately, including the asynchronous clear of the outputs. The pending frame is discarded.

## Test plan
Use `SCAN_DIV`=8, `BLANK_CYCLES`=2.
- Reset then idle 200 cycles: `dot_d`=0 throughout. `dot_scan` steps 0x001→0x002→…→0x200, each high 6 cycles, then 2 cycles of 0. `frame_start` pulses every 80 cycles.
- Accept a frame with column c = c+1 during column 3 of frame N: `frame_ready`=0 until the first cycle of frame N+1. In frame N+1, column 4 DRIVE shows `dot_d`=7'h05 with `dot_scan`=0x010. Frame N shows old data (0).
- Second `frame_valid` held while pending: not accepted (`frame_ready`=0). It is accepted the cycle after the swap, and displayed starting at frame N+2.
- Accept on the exact swap cycle with the shadow empty: the frame is not shown in the next frame and appears one frame later.
- Assert `nreset` during column 6 with a frame pending: `dot_scan`=0, `dot_d`=0, `frame_ready`=1 immediately. After release, scanning restarts at column 0 showing zeros.
- Run with `BLANK_CYCLES`=0: `dot_scan` is never zero after the first edge, and each column is high exactly 8 cycles.
